// File: rtl/man_engine_sched_pkg.sv
// Shared types and default widths for the Mandelbrot engine scheduler.
package man_sched_pkg;

   localparam int NENG_DEF = 4;
   localparam int FPW_DEF  = 54;
   localparam int CW_DEF   = 12;
   localparam int AW_DEF   = 19;
   localparam int IW_DEF   = 8;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_RUN,
      S_DRAIN,
      S_DONE
   } state_e;

endpackage

// File: rtl/man_engine_sched_rr_arbiter.sv
// Round-robin arbiter: one-hot grant, priority starts just after the last
// granted requester; the pointer moves only on the advance strobe.
module rr_arbiter #(
   parameter int N = 4
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic [N-1:0] req_i,
   input  logic         adv_i,
   output logic [N-1:0] gnt_o
);

   localparam int LW = (N > 1) ? $clog2(N) : 1;

   logic [LW-1:0] last_q;
   logic [LW-1:0] gidx;
   logic [LW-1:0] idx;
   logic          found;

   always_comb begin
      gnt_o = '0;
      gidx  = '0;
      idx   = '0;
      found = 1'b0;
      for (int k = 1; k <= N; k++) begin
         idx = LW'((int'(last_q) + k) % N);
         if (!found && req_i[idx]) begin
            found      = 1'b1;
            gnt_o[idx] = 1'b1;
            gidx       = idx;
         end
      end
   end

   // Reset to the top index so the first grant goes to requester 0.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         last_q <= LW'(N - 1);
      end else if (adv_i) begin
         last_q <= gidx;
      end
   end

endmodule

// File: rtl/man_engine_sched.sv
// Raster job generator, round-robin dispatch to NENG engines and result merge.
// Optional MAN_SCHED_STATS_EN adds npixels/cycles statistics outputs.
module man_engine_sched
   import man_sched_pkg::*;
#(
   parameter int NENG = NENG_DEF,
   parameter int FPW  = FPW_DEF,
   parameter int CW   = CW_DEF,
   parameter int AW   = AW_DEF,
   parameter int IW   = IW_DEF
) (
   input  logic             man_clk,
   input  logic             man_rst,
   input  logic             clk_en,
   input  logic             init,
   input  logic [CW-1:0]    hres,
   input  logic [CW-1:0]    vres,
   input  logic [FPW-1:0]   man_x0,
   input  logic [FPW-1:0]   man_y0,
   input  logic [FPW-1:0]   man_xs,
   input  logic [FPW-1:0]   man_ys,
   output logic             done,
   output logic [NENG-1:0]  eng_in_vld,
   input  logic [NENG-1:0]  eng_in_rdy,
   output logic [FPW-1:0]   eng_in_x,
   output logic [FPW-1:0]   eng_in_y,
   output logic [AW-1:0]    eng_in_adr,
   input  logic [NENG-1:0]  eng_out_vld,
   output logic [NENG-1:0]  eng_out_rdy,
   input  logic [NENG*IW-1:0] eng_out_dat,
   input  logic [NENG*AW-1:0] eng_out_adr,
   output logic             out_vld,
   input  logic             out_rdy,
   output logic [IW-1:0]    out_dat,
   output logic [AW-1:0]    out_adr
`ifdef MAN_SCHED_STATS_EN
   ,
   output logic [31:0]      npixels,
   output logic [31:0]      cycles
`endif
);

   localparam int OW = $clog2(NENG + 1);

   state_e         state_q, state_d;
   logic           init_q;
   logic           init_edge;
   logic [CW-1:0]  i_q, i_d, j_q, j_d;
   logic [AW-1:0]  adr_q, adr_d;
   logic [FPW-1:0] x_q, x_d, y_q, y_d;
   logic [OW-1:0]  outst_q, outst_d;
   logic           out_vld_q, out_vld_d;
   logic [IW-1:0]  out_dat_q, out_dat_d;
   logic [AW-1:0]  out_adr_q, out_adr_d;
   logic [NENG-1:0] disp_gnt, coll_gnt;
   logic           disp_xfer, coll_xfer, out_hs, last_pix;
   logic [IW-1:0]  sel_dat;
   logic [AW-1:0]  sel_adr;

   assign init_edge   = init & ~init_q;
   assign eng_in_vld  = (state_q == S_RUN) ? disp_gnt : '0;
   assign disp_xfer   = clk_en & (|(eng_in_vld & eng_in_rdy));
   // The slot can take a new result when empty or being drained this cycle.
   assign eng_out_rdy = (!out_vld_q || out_rdy) ? coll_gnt : '0;
   assign coll_xfer   = clk_en & (|(eng_out_rdy & eng_out_vld));
   assign out_hs      = clk_en & out_vld_q & out_rdy;
   assign last_pix    = (i_q == hres - CW'(1)) && (j_q == vres - CW'(1));

   assign eng_in_x   = x_q;
   assign eng_in_y   = y_q;
   assign eng_in_adr = adr_q;
   assign out_vld    = out_vld_q;
   assign out_dat    = out_dat_q;
   assign out_adr    = out_adr_q;
   assign done       = (state_q == S_DONE);

   rr_arbiter #(.N(NENG)) u_disp_arb (
      .clk_i (man_clk),
      .rst_i (man_rst),
      .req_i (eng_in_rdy),
      .adv_i (disp_xfer),
      .gnt_o (disp_gnt)
   );

   rr_arbiter #(.N(NENG)) u_coll_arb (
      .clk_i (man_clk),
      .rst_i (man_rst),
      .req_i (eng_out_vld),
      .adv_i (coll_xfer),
      .gnt_o (coll_gnt)
   );

   always_comb begin
      sel_dat = '0;
      sel_adr = '0;
      for (int k = 0; k < NENG; k++) begin
         if (coll_gnt[k]) begin
            sel_dat = eng_out_dat[k*IW +: IW];
            sel_adr = eng_out_adr[k*AW +: AW];
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      i_d       = i_q;
      j_d       = j_q;
      adr_d     = adr_q;
      x_d       = x_q;
      y_d       = y_q;
      outst_d   = outst_q + OW'(disp_xfer) - OW'(coll_xfer);
      out_vld_d = out_vld_q;
      out_dat_d = out_dat_q;
      out_adr_d = out_adr_q;

      if (out_hs) begin
         out_vld_d = 1'b0;
      end
      if (coll_xfer) begin
         out_vld_d = 1'b1;
         out_dat_d = sel_dat;
         out_adr_d = sel_adr;
      end

      case (state_q)
         S_IDLE, S_DONE: begin
            if (init_edge) state_d = S_LOAD;
         end
         S_LOAD: begin
            i_d     = '0;
            j_d     = '0;
            adr_d   = '0;
            x_d     = man_x0;
            y_d     = man_y0;
            outst_d = '0;
            state_d = (hres == '0 || vres == '0) ? S_DONE : S_RUN;
         end
         S_RUN: begin
            if (disp_xfer) begin
               adr_d = adr_q + AW'(1);
               if (i_q == hres - CW'(1)) begin
                  i_d = '0;
                  x_d = man_x0;
                  j_d = j_q + CW'(1);
                  y_d = y_q - man_ys;
               end else begin
                  i_d = i_q + CW'(1);
                  x_d = x_q + man_xs;
               end
               if (last_pix) state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            // Look at next-state values so done rises right after the last handshake.
            if (outst_d == '0 && !out_vld_d) state_d = S_DONE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge man_clk or posedge man_rst) begin
      if (man_rst) begin
         state_q   <= S_IDLE;
         init_q    <= 1'b0;
         i_q       <= '0;
         j_q       <= '0;
         adr_q     <= '0;
         x_q       <= '0;
         y_q       <= '0;
         outst_q   <= '0;
         out_vld_q <= 1'b0;
         out_dat_q <= '0;
         out_adr_q <= '0;
      end else if (clk_en) begin
         state_q   <= state_d;
         init_q    <= init;
         i_q       <= i_d;
         j_q       <= j_d;
         adr_q     <= adr_d;
         x_q       <= x_d;
         y_q       <= y_d;
         outst_q   <= outst_d;
         out_vld_q <= out_vld_d;
         out_dat_q <= out_dat_d;
         out_adr_q <= out_adr_d;
      end
   end

`ifdef MAN_SCHED_STATS_EN
   logic [31:0] npix_q, cyc_q;

   always_ff @(posedge man_clk or posedge man_rst) begin
      if (man_rst) begin
         npix_q <= '0;
         cyc_q  <= '0;
      end else if (clk_en) begin
         if (state_q == S_LOAD) begin
            npix_q <= '0;
            cyc_q  <= '0;
         end else if (state_q == S_RUN || state_q == S_DRAIN) begin
            cyc_q <= cyc_q + 32'd1;
            if (out_hs) npix_q <= npix_q + 32'd1;
         end
      end
   end

   assign npixels = npix_q;
   assign cycles  = cyc_q;
`endif

endmodule

// File: doc/man_engine_sched.md
Name: man_engine_sched

Overview:
Scheduler that shares the screen-pixel workload across NENG parallel Mandelbrot iteration engines in the man_clk domain. On a synchronised init edge it walks the hres x vres raster and generates fixed-point coordinates (x0 + i*xs, y0 - j*ys) plus linear pixel address. It dispatches each pixel round-robin to a free engine, then merges the engines' completed results into the single out_vld/out_rdy stream that feeds the video async fifo. It raises done once every pixel has been delivered downstream.

Parameters:
NENG, 4, number of iteration engines
FPW, 54, fixed-point coordinate width
CW, 12, screen counter width
AW, 19, pixel address width
IW, 8, iteration-count width

Ports:
man_clk  in  1  clock
man_rst  in  1  reset
clk_en  in  1  clock enable; all state advances only when high
init  in  1  start; rising-edge sensitive, already synchronised
hres, vres  in  CW each  horizontal/vertical pixel count
man_x0, man_y0, man_xs, man_ys  in  FPW each  origin and steps
done  out  1  frame complete
eng_in_vld  out  NENG  per-engine job valid
eng_in_rdy  in  NENG  per-engine job ready
eng_in_x, eng_in_y  out  FPW  job coordinate, shared by all engines
eng_in_adr  out  AW  job address, shared by all engines
eng_out_vld  in  NENG  per-engine result valid
eng_out_rdy  out  NENG  per-engine result accept
eng_out_dat  in  NENG*IW  results, flattened, engine k at [k*IW +: IW]
eng_out_adr  in  NENG*AW  result addresses, flattened
out_vld  out  1  merged result valid
out_rdy  in  1  downstream ready
out_dat  out  IW  iteration count
out_adr  out  AW  pixel address

Behaviour:
- Reset, asynchronous, active-high, clock man_clk: state=IDLE; done, out_vld, eng_in_vld, eng_out_rdy = 0; counters, out_dat, out_adr = 0.
- FSM:
  - IDLE/DONE -> LOAD on init rising edge (init registered; edge = init & ~init_q).
  - LOAD, 1 cycle: i=j=0, adr=0, x=x0, y=y0, outstanding=0, done=0.
  - LOAD -> RUN, unless hres==0 or vres==0, in which case LOAD -> DONE directly.
  - RUN -> DRAIN after the last pixel is dispatched.
  - DRAIN -> DONE when outstanding==0 and out_vld==0.
  - DONE holds done=1 until the next init edge.
- Init edges in LOAD/RUN/DRAIN are ignored; there is no mid-frame restart.
- Dispatch:
  - In RUN, eng_in_vld is one-hot at most: the round-robin grant among eng_in_rdy, starting after the last granted engine.
  - A transfer occurs when eng_in_vld[k] & eng_in_rdy[k] & clk_en; at most one per cycle.
  - On transfer: adr+=1; x+=xs.
  - If i==hres-1: i=0, x=x0, j+=1, y-=ys; otherwise i+=1.
  - The last pixel is i==hres-1 and j==vres-1.
  - eng_in_x/y/adr reflect current generator registers, combinational from regs, stable while no transfer.
  - Coordinate arithmetic wraps modulo 2^FPW, two's complement. The address counter is AW bits; wrap is never reached for legal hres*vres <= 2^AW.
- Collect:
  - Output slot is 1 deep.
  - eng_out_rdy is one-hot: round-robin grant among eng_out_vld, asserted only when out_vld==0 or out_rdy==1 (slot freeing this cycle).
  - On accept, out_dat/out_adr load the granted engine's data next cycle with out_vld=1.
  - out_vld holds with stable data until out_rdy.
- outstanding = dispatched - collected, width clog2(NENG+1) bits; a simultaneous dispatch and collect leaves it unchanged.
- A result arriving in LOAD is impossible, since outstanding==0 is guaranteed by DRAIN.
- Latency:
  - Init edge to first eng_in_vld: 3 clk_en cycles (edge reg, LOAD, RUN).
  - Engine result to out_vld: 1 cycle.
  - Last out handshake to done=1: 1 cycle.

Optional Feature:
MAN_SCHED_STATS_EN: adds outputs npixels[31:0] (pixels delivered downstream) and cycles[31:0] (clk_en cycles from LOAD to DONE).
- Both counters clear in LOAD and freeze in DONE.
- Without the macro the ports and counters do not exist, and behaviour is otherwise identical.

Decomposition:
- Package man_sched_pkg: FSM state enum (IDLE, LOAD, RUN, DRAIN, DONE) and default width constants.
- Sub-module rr_arbiter #(N): request vector and advance strobe in, one-hot grant out, rotating priority pointer. Instantiated twice, once for dispatch and once for collect.

Test Plan:
- hres=4, vres=2, NENG=4, x0=0, xs=1, y0=0, ys=1, engines always ready with fixed latency 5 -> 8 outputs, addresses 0..7 each exactly once; row 1 jobs have x=0..3, y=-1; done=1 one cycle after the 8th out handshake.
- All engines ready every cycle -> dispatch order 0,1,2,3,0,1,... and one job per clk_en cycle.
- out_rdy held low 20 cycles mid-frame -> out_vld/dat/adr stable, eng_out_rdy all 0; no result lost or duplicated; done delayed accordingly.
- Two engines assert eng_out_vld in the same cycle -> accepted on consecutive cycles in round-robin order, outstanding decrements by 1 each.
- hres=0 -> done=1 within 3 cycles of init with no eng_in_vld ever.
- Second init pulse during RUN -> ignored; frame completes normally, and a new init after done restarts with done dropping in LOAD.
